seq_demux_pair: RTL and testbench
=================================

# seq_demux_pair

Sequential 1-to-2 demultiplexer and pair assembler: the receiving end of a lane-multiplexed link that carries two WIDTH-bit operands, X and Y, over one shared bus, tagged by select S. Each accepted input beat is routed to the X or Y holding register by S. Once both lanes hold data, the block presents a registered {X, Y} pair downstream under a ready/valid handshake. It sits between a time-shared 2:1 mux link and any consumer that needs both operands together.

## Interface
Parameters:
- WIDTH, 2, width of each lane (I, X, Y)
- CNT_W, 8, width of the delivered-pair counter

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- RST  in  1  synchronous, active-high reset
- I  in  WIDTH  input data beat
- S  in  1  lane select for the current beat (0 = X lane, 1 = Y lane)
- I_VALID  in  1  input beat valid
- I_READY  out  1  block can accept a beat for lane S this cycle (combinational)
- X  out  WIDTH  X operand of the presented pair (registered)
- Y  out  WIDTH  Y operand of the presented pair (registered)
- O_VALID  out  1  pair {X, Y} valid (registered)
- O_READY  in  1  consumer accepts the pair
- COUNT  out  CNT_W  number of pairs delivered, modulo 2^CNT_W

## Operation
- States: EMPTY, HAVE_X, HAVE_Y, FULL. The lane-full flags fx and fy encode the state (EMPTY=00, HAVE_X=10, HAVE_Y=01, FULL=11, written as fx,fy). O_VALID = (state == FULL).
- Input accept: beat accepted when I_VALID && I_READY.
  - S=0: write X and set fx.
  - S=1: write Y and set fy.
- I_READY = !full[S] || (O_VALID && O_READY). A beat aimed at an already-filled lane stalls; the existing data is never overwritten.
- Output accept: pair transferred when O_VALID && O_READY. On transfer, fx and fy clear and COUNT increments.
- Simultaneous transfer and accept in FULL: the pair leaves and the new beat loads its lane in the same edge.
  - S=0: next state HAVE_X.
  - S=1: next state HAVE_Y.
  - COUNT increments.
- Transitions:
  - EMPTY to HAVE_X on an S=0 accept; EMPTY to HAVE_Y on an S=1 accept.
  - HAVE_X to FULL on an S=1 accept. An S=0 beat in HAVE_X stalls (I_READY=0).
  - HAVE_Y to FULL on an S=0 accept. An S=1 beat in HAVE_Y stalls.
  - FULL to EMPTY on a transfer with no accepted beat.
  - FULL holds while O_READY=0. X and Y stay stable while O_VALID=1 and O_READY=0.
- COUNT wraps from 2^CNT_W-1 to 0 with no flag.
- X and Y are don't-care while O_VALID=0, but they must hold their last written value (no spurious updates).
- I_VALID=0: no state change. I and S are ignored.

## Timing
- Reset: RST=1 at an edge forces EMPTY, X=0, Y=0, O_VALID=0, COUNT=0. It overrides any simultaneous accept or transfer. While RST=1, I_READY reads as 1 but beats are discarded.
- Reset mid-pair (HAVE_X or HAVE_Y) discards the partial pair. Reset in FULL drops the pair without counting it.
- Latency: O_VALID rises on the edge that accepts the second lane's beat. The pair is visible one cycle after that beat is presented.
- Throughput: one beat per cycle. A sustained alternating S stream with O_READY=1 delivers one pair every 2 cycles with no stall.
- I_READY depends combinationally on S, O_READY and state. It must not depend on I_VALID.

## Structure
- Package seq_demux_pkg: state encoding constants ST_EMPTY, ST_HAVE_X, ST_HAVE_Y, ST_FULL, and the lane index constants LANE_X=0 and LANE_Y=1.
- Sub-module demux_lane_reg (WIDTH): one holding register with a load enable, a full flag, and a clear. It is instantiated twice, with load enable = accept && (S == lane) and clear = transfer && !(accept && S == lane).
- The top level holds the ready/valid logic and COUNT.

## Test plan
- Basic pair: after reset, I=1 S=0, then I=2 S=1 with O_READY=1. Required: O_VALID=1 for exactly one cycle with X=1, Y=2, then COUNT=1.
- Reverse order and stall: I=3 S=1, then I=2 S=0 with O_READY=0. Required: X=2, Y=3 held. A further S=0 beat sees I_READY=0. O_READY=1 then transfers the pair, and the stalled beat is accepted in the same cycle, giving HAVE_X.
- Duplicate lane: two consecutive S=0 beats (I=1, then I=3). Required: second beat stalled (I_READY=0), X stays 1, O_VALID=0.
- Streaming: alternating S=0/1 beats with I_VALID=1 and O_READY=1 for 20 cycles. Required: 10 pairs, no I_READY deassertion, COUNT=10.
- Wrap: CNT_W=2 and 5 pairs. Required: COUNT sequence 1, 2, 3, 0, 1.
- Mid-operation reset: HAVE_X (X=2), then RST=1 for 1 cycle. Required: O_VALID=0, X=0, COUNT=0. A following S=1 beat moves to HAVE_Y, not FULL.

Source files
------------

// File: rtl/seq_demux_pkg.sv
// Shared types for the sequential demux / pair assembler: state encoding
// (lane-full flags fx,fy) and lane index constants.
package seq_demux_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'b00,
    ST_HAVE_Y = 2'b01,
    ST_HAVE_X = 2'b10,
    ST_FULL   = 2'b11
  } state_t;

  localparam logic LANE_X = 1'b0;
  localparam logic LANE_Y = 1'b1;

endpackage

// File: rtl/seq_demux_pair_lane_reg.sv
// One lane holding register: loads on enable, tracks a full flag, and
// releases the flag on clear while keeping the stored data stable.
module demux_lane_reg #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             full
);

  logic [WIDTH-1:0] data_r;
  logic             full_r;

  // Data and full flag; load wins over clear so a same-edge refill stays full.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_r <= {WIDTH{1'b0}};
      full_r <= 1'b0;
    end else if (load) begin
      data_r <= d;
      full_r <= 1'b1;
    end else if (clear) begin
      data_r <= data_r;
      full_r <= 1'b0;
    end else begin
      data_r <= data_r;
      full_r <= full_r;
    end
  end

  assign q    = data_r;
  assign full = full_r;

endmodule

// File: rtl/seq_demux_pair.sv
// Receiving end of a lane-multiplexed link: steers beats into X/Y holding
// registers by S and presents the assembled {X, Y} pair under ready/valid.
module seq_demux_pair
  import seq_demux_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] I,
  input  logic             S,
  input  logic             I_VALID,
  output logic             I_READY,
  output logic [WIDTH-1:0] X,
  output logic [WIDTH-1:0] Y,
  output logic             O_VALID,
  input  logic             O_READY,
  output logic [CNT_W-1:0] COUNT
);

  logic             fx_s;
  logic             fy_s;
  state_t           state_s;
  logic             lane_full_s;
  logic             transfer_s;
  logic             ready_s;
  logic             accept_s;
  logic             load_x_s;
  logic             load_y_s;
  logic             clr_x_s;
  logic             clr_y_s;
  logic [CNT_W-1:0] count_r;

  // Next-state decode: which lane is blocked and whether the pair leaves.
  always_comb begin
    state_s     = state_t'({fx_s, fy_s});
    lane_full_s = 1'b0;
    transfer_s  = 1'b0;
    case (state_s)
      ST_EMPTY:  lane_full_s = 1'b0;
      ST_HAVE_X: lane_full_s = (S == LANE_X);
      ST_HAVE_Y: lane_full_s = (S == LANE_Y);
      ST_FULL: begin
        lane_full_s = 1'b1;
        transfer_s  = O_READY;
      end
      default: begin
        lane_full_s = 1'b1;
        transfer_s  = 1'b0;
      end
    endcase

    // Reset reports ready but the lane registers discard the beat.
    if (RST) begin
      ready_s = 1'b1;
    end else begin
      ready_s = !lane_full_s || transfer_s;
    end

    accept_s = I_VALID && ready_s && !RST;
    load_x_s = accept_s && (S == LANE_X);
    load_y_s = accept_s && (S == LANE_Y);
    clr_x_s  = transfer_s && !load_x_s;
    clr_y_s  = transfer_s && !load_y_s;
  end

  demux_lane_reg #(.WIDTH(WIDTH)) u_lane_x (
    .clk   (CLK),
    .rst   (RST),
    .load  (load_x_s),
    .clear (clr_x_s),
    .d     (I),
    .q     (X),
    .full  (fx_s)
  );

  demux_lane_reg #(.WIDTH(WIDTH)) u_lane_y (
    .clk   (CLK),
    .rst   (RST),
    .load  (load_y_s),
    .clear (clr_y_s),
    .d     (I),
    .q     (Y),
    .full  (fy_s)
  );

  // Delivered-pair counter, wraps silently.
  always_ff @(posedge CLK) begin
    if (RST) begin
      count_r <= {CNT_W{1'b0}};
    end else if (transfer_s) begin
      count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign I_READY = ready_s;
  assign O_VALID = fx_s & fy_s;
  assign COUNT   = count_r;

endmodule

// File: tb/tb_seq_demux_pair.sv
// Directed plus randomized bench for seq_demux_pair, checked against a
// lane-occupancy reference model; a second instance uses a 2-bit counter.
module tb_seq_demux_pair;

  localparam int W = 2;

  logic         CLK = 1'b0;
  logic         RST;
  logic [W-1:0] I;
  logic         S;
  logic         I_VALID;
  logic         O_READY;

  logic         I_READY, O_VALID;
  logic [W-1:0] X, Y;
  logic [7:0]   COUNT;

  logic         I_READY_w, O_VALID_w;
  logic [W-1:0] X_w, Y_w;
  logic [1:0]   COUNT_w;

  int checks   = 0;
  int failures = 0;

  // reference model: which lanes hold data, the data, and pairs delivered
  logic [1:0]   has_m;
  logic [W-1:0] data_m [2];
  int           pairs_m;

  logic [1:0] wrap_seq [5];

  seq_demux_pair #(.WIDTH(W), .CNT_W(8)) dut (
    .CLK(CLK), .RST(RST), .I(I), .S(S), .I_VALID(I_VALID), .I_READY(I_READY),
    .X(X), .Y(Y), .O_VALID(O_VALID), .O_READY(O_READY), .COUNT(COUNT)
  );

  seq_demux_pair #(.WIDTH(W), .CNT_W(2)) dut_w (
    .CLK(CLK), .RST(RST), .I(I), .S(S), .I_VALID(I_VALID), .I_READY(I_READY_w),
    .X(X_w), .Y(Y_w), .O_VALID(O_VALID_w), .O_READY(O_READY), .COUNT(COUNT_w)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock: drive at negedge, check ready, update model at posedge, check outputs
  task automatic cycle(input logic rst, input logic v, input logic s,
                       input logic [W-1:0] i, input logic ordy);
    logic xfer;
    logic exp_ready;
    @(negedge CLK);
    RST = rst; I_VALID = v; S = s; I = i; O_READY = ordy;
    #1;
    xfer      = has_m[0] && has_m[1] && ordy;
    exp_ready = rst ? 1'b1 : (!has_m[s] || xfer);
    chk("i_ready",   32'(I_READY),   32'(exp_ready));
    chk("i_ready_w", 32'(I_READY_w), 32'(exp_ready));
    @(posedge CLK);
    if (rst) begin
      has_m     = 2'b00;
      data_m[0] = '0;
      data_m[1] = '0;
      pairs_m   = 0;
    end else begin
      if (xfer) begin
        pairs_m++;
        has_m = 2'b00;
      end
      if (v && exp_ready) begin
        data_m[s] = i;
        has_m[s]  = 1'b1;
      end
    end
    #1;
    chk("o_valid",  32'(O_VALID),   32'(has_m[0] && has_m[1]));
    chk("x",        32'(X),         32'(data_m[0]));
    chk("y",        32'(Y),         32'(data_m[1]));
    chk("count",    32'(COUNT),     32'(pairs_m % 256));
    chk("o_valid_w",32'(O_VALID_w), 32'(has_m[0] && has_m[1]));
    chk("count_w",  32'(COUNT_w),   32'(pairs_m % 4));
  endtask

  initial begin
    has_m = 2'b00; data_m[0] = '0; data_m[1] = '0; pairs_m = 0;
    wrap_seq[0] = 2'd1; wrap_seq[1] = 2'd2; wrap_seq[2] = 2'd3;
    wrap_seq[3] = 2'd0; wrap_seq[4] = 2'd1;
    RST = 1'b1; I = '0; S = 1'b0; I_VALID = 1'b0; O_READY = 1'b0;

    cycle(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 2'd3, 1'b1);
    chk("reset_valid", 32'(O_VALID), 32'd0);
    chk("reset_count", 32'(COUNT), 32'd0);

    // basic pair
    cycle(1'b0, 1'b1, 1'b0, 2'd1, 1'b1);
    cycle(1'b0, 1'b1, 1'b1, 2'd2, 1'b1);
    chk("basic_valid", 32'(O_VALID), 32'd1);
    chk("basic_x", 32'(X), 32'd1);
    chk("basic_y", 32'(Y), 32'd2);
    cycle(1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
    chk("basic_count", 32'(COUNT), 32'd1);
    chk("basic_one_cycle", 32'(O_VALID), 32'd0);

    // reverse order, held pair, stalled beat accepted on transfer
    cycle(1'b0, 1'b1, 1'b1, 2'd3, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 2'd2, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 2'd1, 1'b0);
    chk("hold_x", 32'(X), 32'd2);
    chk("hold_y", 32'(Y), 32'd3);
    chk("hold_valid", 32'(O_VALID), 32'd1);
    cycle(1'b0, 1'b1, 1'b0, 2'd1, 1'b1);
    chk("xfer_accept_valid", 32'(O_VALID), 32'd0);
    chk("xfer_accept_x", 32'(X), 32'd1);
    chk("xfer_accept_count", 32'(COUNT), 32'd2);

    // duplicate lane stalls
    cycle(1'b0, 1'b1, 1'b0, 2'd3, 1'b1);
    chk("dup_x", 32'(X), 32'd1);
    chk("dup_valid", 32'(O_VALID), 32'd0);
    cycle(1'b0, 1'b1, 1'b1, 2'd0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 2'd0, 1'b1);

    // streaming: 20 alternating beats then drain
    cycle(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      cycle(1'b0, 1'b1, 1'(k % 2), W'(k), 1'b1);
    end
    cycle(1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
    chk("stream_count", 32'(COUNT), 32'd10);
    chk("stream_count_w", 32'(COUNT_w), 32'd2);

    // counter wrap on the 2-bit instance
    cycle(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    for (int p = 0; p < 5; p++) begin
      cycle(1'b0, 1'b1, 1'b0, W'(p), 1'b1);
      cycle(1'b0, 1'b1, 1'b1, W'(p + 1), 1'b1);
      cycle(1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
      chk("wrap_count", 32'(COUNT_w), 32'(wrap_seq[p]));
    end

    // reset mid-pair
    cycle(1'b0, 1'b1, 1'b0, 2'd2, 1'b0);
    chk("mid_x", 32'(X), 32'd2);
    cycle(1'b1, 1'b1, 1'b1, 2'd1, 1'b1);
    chk("mid_rst_valid", 32'(O_VALID), 32'd0);
    chk("mid_rst_x", 32'(X), 32'd0);
    chk("mid_rst_count", 32'(COUNT), 32'd0);
    cycle(1'b0, 1'b1, 1'b1, 2'd1, 1'b0);
    chk("mid_have_y_valid", 32'(O_VALID), 32'd0);
    chk("mid_have_y_y", 32'(Y), 32'd1);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      cycle(1'($urandom_range(39, 0) == 0), 1'($urandom_range(3, 0) != 0),
            1'($urandom), W'($urandom), 1'($urandom_range(2, 0) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
